// File: rtl/bitop_result_fifo.sv
// bitop_result_fifo: selects one bitwise-op result and queues {op_sel, result} in a FIFO with a stall counter
module bitop_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               res_and,
  input  logic [2:0]               res_or,
  input  logic [2:0]               res_xor,
  input  logic [2:0]               res_not,
  input  logic [1:0]               op_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0] mem_q [DEPTH];
  logic [4:0] mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0] count_q, count_d;
  logic [7:0] stall_q, stall_d;
  logic [2:0] sel;
  logic push, pop;
  assign in_ready  = count_q < (AW+1)'(DEPTH);
  assign out_valid = count_q != '0;
  assign out_data  = out_valid ? mem_q[head_q] : 5'b00000;
  assign count     = count_q;
  assign stall_cnt = stall_q;
  always_comb begin
    sel = op_sel == 2'b00 ? res_and : op_sel == 2'b01 ? res_or : op_sel == 2'b10 ? res_xor : res_not;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    mem_d = mem_q;
    if (push) mem_d[tail_q] = {op_sel, sel};
    head_d = pop ? head_q + AW'(1) : head_q;
    tail_d = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    stall_d = stall_q + 8'(in_valid && !in_ready && stall_q != 8'hff);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_bitop_result_fifo.sv
// tb_bitop_result_fifo: directed and random checks of bitop_result_fifo against a queue model
module tb_bitop_result_fifo;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 0;
  logic rst_n = 0;
  logic [2:0] res_and = 0, res_or = 0, res_xor = 0, res_not = 0;
  logic [1:0] op_sel = 0;
  logic in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [4:0] out_data;
  logic [CW-1:0] count;
  logic [7:0] stall_cnt;
  int vectors = 0, errs = 0;
  logic [4:0] q[$];
  int stall_m = 0;
  bitop_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .res_and(res_and), .res_or(res_or), .res_xor(res_xor),
    .res_not(res_not), .op_sel(op_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [1:0] op, input logic [2:0] a, o, x, n,
                      input logic rdy, input logic rn);
    logic [2:0] r;
    int sz;
    in_valid = v; op_sel = op; res_and = a; res_or = o; res_xor = x; res_not = n;
    out_ready = rdy; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      stall_m = 0;
    end else begin
      sz = q.size();
      case (op)
        2'd0: r = a;
        2'd1: r = o;
        2'd2: r = x;
        default: r = n;
      endcase
      if (v && sz >= DEPTH && stall_m < 255) stall_m++;
      if (rdy && sz > 0) void'(q.pop_front());
      if (v && sz < DEPTH) q.push_back({op, r});
    end
    #1;
    check("in_ready", in_ready, q.size() < DEPTH);
    check("out_valid", out_valid, q.size() != 0);
    check("out_data", out_data, q.size() != 0 ? q[0] : 5'b00000);
    check("count", count, q.size());
    check("stall_cnt", stall_cnt, stall_m);
  endtask
  task automatic idle(input logic rdy);
    step(0, 0, 0, 0, 0, 0, rdy, 1);
  endtask
  task automatic push_rand(input logic rdy);
    step(1, 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), rdy, 1);
  endtask
  initial begin
    logic [4:0] exp36 [4];
    exp36[0] = 5'b00001; exp36[1] = 5'b01111; exp36[2] = 5'b10110; exp36[3] = 5'b11010;
    step(1, 2'b10, 3'b001, 3'b111, 3'b110, 3'b010, 1, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    // single push, single pop
    step(1, 2'b10, 3'b001, 3'b111, 3'b110, 3'b010, 0, 1);
    check("r35_data", out_data, 5'b10110);
    check("r35_count", count, 1);
    idle(1);
    check("r35_empty", out_valid, 0);
    // select coverage
    for (int i = 0; i < 4; i++) step(1, 2'(i), 3'b001, 3'b111, 3'b110, 3'b010, 0, 1);
    for (int i = 0; i < 4; i++) begin
      check("r36_order", out_data, exp36[i]);
      idle(1);
    end
    idle(1);
    check("r36_empty_pop", count, 0);
    // full and stall
    for (int i = 0; i < 10; i++) push_rand(0);
    check("r37_count", count, 4);
    check("r37_stall", stall_cnt, 6);
    step(1, 0, 1, 1, 1, 1, 1, 1);
    check("r23_full_pop", count, 3);
    // simultaneous push and pop at count=2
    step(0, 0, 0, 0, 0, 0, 0, 0);
    push_rand(0);
    push_rand(0);
    for (int i = 0; i < 20; i++) push_rand(1);
    check("r38_count", count, 2);
    // saturation
    for (int i = 0; i < 300; i++) push_rand(0);
    check("r39_sat", stall_cnt, 255);
    // reset mid-stream at count=3
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) push_rand(0);
    step(1, 0, 1, 1, 1, 1, 1, 0);
    check("r40_count", count, 0);
    check("r40_valid", out_valid, 0);
    check("r40_stall", stall_cnt, 0);
    step(1, 2'b01, 3'b000, 3'b101, 3'b000, 3'b000, 0, 1);
    check("r40_head", out_data, 5'b01101);
    check("r40_alone", count, 1);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(1'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
           (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           $urandom_range(0, 99) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
